// File: rtl/jesd204b_tpl_tx_if.sv
// Transport-layer TX bundle: sample/control input stream and packed lane frame output stream.
// master = frame source and lane sink; slave = the transport layer itself.
interface jesd204b_tpl_tx_if #(
    parameter int LANES       = 4,
    parameter int CONVERTERS  = 8,
    parameter int RESOLUTION  = 11,
    parameter int CONTROL     = 2,
    parameter int SAMPLE_SIZE = 16,
    parameter int SAMPLES     = 1
);
    localparam int CPAD  = CONVERTERS + (LANES - CONVERTERS % LANES) * ((CONVERTERS % LANES) != 0 ? 1 : 0);
    localparam int OUT_W = SAMPLES * SAMPLE_SIZE * CPAD;

    logic [SAMPLES*CONVERTERS*RESOLUTION-1:0] tx_datain;
    logic [SAMPLES*CONVERTERS*CONTROL-1:0]    tx_ctrlin;
    logic                                     in_valid;
    logic                                     in_ready;
    logic [OUT_W-1:0]                         tx_dataout;
    logic                                     out_valid;
    logic                                     out_ready;
    logic                                     tx_sof;
    logic [7:0]                               frame_idx;

    modport master (
        output tx_datain, tx_ctrlin, in_valid, out_ready,
        input  in_ready, tx_dataout, out_valid, tx_sof, frame_idx
    );

    modport slave (
        input  tx_datain, tx_ctrlin, in_valid, out_ready,
        output in_ready, tx_dataout, out_valid, tx_sof, frame_idx
    );
endinterface

// File: rtl/jesd204b_tpl_tx.sv
// JESD204B transport-layer TX: packs samples+control into SAMPLE_SIZE words across LANES, 1-cycle latency,
// 2-entry output buffer; in_ready depends only on occupancy, output held stable while out_ready is low.
module jesd204b_tpl_tx #(
    parameter int LANES         = 4,
    parameter int CONVERTERS    = 8,
    parameter int RESOLUTION    = 11,
    parameter int CONTROL       = 2,
    parameter int SAMPLE_SIZE   = 16,
    parameter int SAMPLES       = 1,
    parameter int FRAMES_PER_MF = 32
) (
    input  logic clk,
    input  logic rst,
    jesd204b_tpl_tx_if.slave bus
);
    localparam int CPAD  = CONVERTERS + (LANES - CONVERTERS % LANES) * ((CONVERTERS % LANES) != 0 ? 1 : 0);
    localparam int OUT_W = SAMPLES * SAMPLE_SIZE * CPAD;
    localparam int TAIL  = SAMPLE_SIZE - RESOLUTION - CONTROL;
    localparam logic [7:0] FC_LAST = 8'(FRAMES_PER_MF - 1);

    generate
        if (RESOLUTION + CONTROL > SAMPLE_SIZE) begin : g_bad_sample_size
            $error("jesd204b_tpl_tx: RESOLUTION+CONTROL exceeds SAMPLE_SIZE");
        end
        if (FRAMES_PER_MF < 1 || FRAMES_PER_MF > 256) begin : g_bad_k
            $error("jesd204b_tpl_tx: FRAMES_PER_MF must be 1..256");
        end
    endgenerate

    logic [OUT_W-1:0] packed_frame;
    logic [OUT_W-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count;
    logic [7:0]       fc;
    logic             push;
    logic             pop;

    // Word layout {sample, ctrl, zero tail}; dummy converter slots stay zero from the default.
    always_comb begin
        packed_frame = '0;
        for (int c = 0; c < CONVERTERS; c++) begin
            for (int s = 0; s < SAMPLES; s++) begin
                packed_frame[(c*SAMPLES+s)*SAMPLE_SIZE + TAIL + CONTROL +: RESOLUTION] =
                    bus.tx_datain[(c*SAMPLES+s)*RESOLUTION +: RESOLUTION];
                packed_frame[(c*SAMPLES+s)*SAMPLE_SIZE + TAIL +: CONTROL] =
                    bus.tx_ctrlin[(c*SAMPLES+s)*CONTROL +: CONTROL];
            end
        end
    end

    assign bus.in_ready   = (count != 2'd2);
    assign bus.out_valid  = (count != 2'd0);
    assign push           = bus.in_valid & bus.in_ready;
    assign pop            = bus.out_valid & bus.out_ready;
    assign bus.tx_dataout = mem[rd_ptr];
    assign bus.frame_idx  = fc;
    assign bus.tx_sof     = bus.out_valid & (fc == 8'd0);

    // Push only ever targets the free slot, so the head entry is never overwritten while held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            fc     <= 8'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= packed_frame;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
                fc     <= (fc == FC_LAST) ? 8'd0 : fc + 8'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_jesd204b_tpl_tx.sv
module tb_jesd204b_tpl_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    jesd204b_tpl_tx_if #(.LANES(4), .CONVERTERS(8)) bus0 ();
    jesd204b_tpl_tx_if #(.LANES(2), .CONVERTERS(3)) bus1 ();
    jesd204b_tpl_tx_if #(.LANES(4), .CONVERTERS(8)) bus2 ();

    jesd204b_tpl_tx #(.LANES(4), .CONVERTERS(8), .FRAMES_PER_MF(32)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    jesd204b_tpl_tx #(.LANES(2), .CONVERTERS(3), .FRAMES_PER_MF(32)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    jesd204b_tpl_tx #(.LANES(4), .CONVERTERS(8), .FRAMES_PER_MF(4))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [87:0]  din;
        logic [15:0]  cin;
        logic [127:0] exp;
    } vec_t;

    localparam logic [127:0] FA = {8{16'h0020}};
    localparam logic [127:0] FB = {8{16'h0040}};
    localparam logic [127:0] FC = {8{16'h0060}};

    vec_t vecs [5];

    initial begin
        vecs[0] = '{din: {8{11'h71B}}, cin: 16'h0000, exp: 128'he360e360_e360e360_e360e360_e360e360};
        vecs[1] = '{din: {11'h67B, 77'd0}, cin: {2'b00, 12'd0, 2'b11}, exp: 128'hcf600000_00000000_00000000_00000018};
        vecs[2] = '{din: 88'd0, cin: {8{2'b01}}, exp: {8{16'h0008}}};
        vecs[3] = '{din: {11'd7, 11'd6, 11'd5, 11'd4, 11'd3, 11'd2, 11'd1, 11'd0}, cin: {8{2'b10}},
                    exp: 128'h00f000d0_00b00090_00700050_00300010};
        vecs[4] = '{din: {8{11'h400}}, cin: {8{2'b11}}, exp: {8{16'h8018}}};

        bus0.in_valid = 1'b0; bus0.out_ready = 1'b1; bus0.tx_datain = '0; bus0.tx_ctrlin = '0;
        bus1.in_valid = 1'b0; bus1.out_ready = 1'b1; bus1.tx_datain = '0; bus1.tx_ctrlin = '0;
        bus2.in_valid = 1'b0; bus2.out_ready = 1'b1; bus2.tx_datain = '0; bus2.tx_ctrlin = '0;

        repeat (2) @(negedge clk);
        check("rst_out_valid", 128'(bus0.out_valid), 128'd0);
        check("rst_in_ready", 128'(bus0.in_ready), 128'd1);
        check("rst_dataout", bus0.tx_dataout, 128'd0);
        check("rst_sof", 128'(bus0.tx_sof), 128'd0);
        check("rst_frame_idx", 128'(bus0.frame_idx), 128'd0);
        rst = 1'b0;

        // Back-to-back table vectors; each is popped while the next is pushed.
        for (int i = 0; i < 5; i++) begin
            bus0.tx_datain = vecs[i].din;
            bus0.tx_ctrlin = vecs[i].cin;
            bus0.in_valid = 1'b1;
            @(negedge clk);
            check($sformatf("vec%0d_valid", i), 128'(bus0.out_valid), 128'd1);
            check($sformatf("vec%0d_data", i), bus0.tx_dataout, vecs[i].exp);
            check($sformatf("vec%0d_idx", i), 128'(bus0.frame_idx), 128'(i));
            check($sformatf("vec%0d_sof", i), 128'(bus0.tx_sof), 128'(i == 0));
            if (i == 1) begin
                check("lane0", 128'(bus0.tx_dataout[31:0]), 128'h00000018);
                check("lane3", 128'(bus0.tx_dataout[127:96]), 128'hcf600000);
            end
        end
        bus0.in_valid = 1'b0;
        @(negedge clk);
        check("drained", 128'(bus0.out_valid), 128'd0);

        // Non-multiple converter count: one zero dummy word.
        bus1.tx_datain = {3{11'h7FF}};
        bus1.in_valid = 1'b1;
        @(negedge clk);
        bus1.in_valid = 1'b0;
        check("c3_valid", 128'(bus1.out_valid), 128'd1);
        check("c3_data", 128'(bus1.tx_dataout), 128'h0000ffe0_ffe0ffe0);

        // K=4 multiframe wrap over 9 streamed frames.
        for (int i = 0; i < 9; i++) begin
            bus2.tx_datain = {8{11'(i)}};
            bus2.in_valid = 1'b1;
            @(negedge clk);
            check($sformatf("mf%0d_valid", i), 128'(bus2.out_valid), 128'd1);
            check($sformatf("mf%0d_idx", i), 128'(bus2.frame_idx), 128'(i % 4));
            check($sformatf("mf%0d_sof", i), 128'(bus2.tx_sof), 128'(i % 4 == 0));
            check($sformatf("mf%0d_data", i), 128'(bus2.tx_dataout[15:0]), 128'(i * 32));
        end
        bus2.in_valid = 1'b0;

        // Backpressure: A, B fill the buffer, C is refused until a pop.
        bus0.out_ready = 1'b0;
        bus0.tx_datain = {8{11'h001}}; bus0.tx_ctrlin = '0; bus0.in_valid = 1'b1;
        @(negedge clk);
        bus0.tx_datain = {8{11'h002}};
        @(negedge clk);
        bus0.tx_datain = {8{11'h003}};
        check("full_in_ready", 128'(bus0.in_ready), 128'd0);
        @(negedge clk);
        check("hold_a_data", bus0.tx_dataout, FA);
        check("hold_a_idx", 128'(bus0.frame_idx), 128'd5);
        check("hold_a_sof", 128'(bus0.tx_sof), 128'd0);
        check("hold_in_ready", 128'(bus0.in_ready), 128'd0);
        @(negedge clk);
        check("hold_a_stable", bus0.tx_dataout, FA);
        bus0.out_ready = 1'b1;
        @(negedge clk);
        check("pop_b_data", bus0.tx_dataout, FB);
        check("pop_b_idx", 128'(bus0.frame_idx), 128'd6);
        check("pop_b_in_ready", 128'(bus0.in_ready), 128'd1);
        @(negedge clk);
        bus0.in_valid = 1'b0;
        check("pop_c_data", bus0.tx_dataout, FC);
        check("pop_c_idx", 128'(bus0.frame_idx), 128'd7);
        @(negedge clk);
        check("bp_empty", 128'(bus0.out_valid), 128'd0);

        // Asynchronous reset with two frames buffered.
        bus0.out_ready = 1'b0;
        bus0.tx_datain = {8{11'h001}}; bus0.in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_full", 128'(bus0.in_ready), 128'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", 128'(bus0.out_valid), 128'd0);
        check("arst_in_ready", 128'(bus0.in_ready), 128'd1);
        check("arst_idx", 128'(bus0.frame_idx), 128'd0);
        check("arst_data", bus0.tx_dataout, 128'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus0.in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_empty", 128'(bus0.out_valid), 128'd0);
        bus0.out_ready = 1'b1;
        bus0.tx_datain = {8{11'h002}}; bus0.in_valid = 1'b1;
        @(negedge clk);
        bus0.in_valid = 1'b0;
        check("post_rst_valid", 128'(bus0.out_valid), 128'd1);
        check("post_rst_sof", 128'(bus0.tx_sof), 128'd1);
        check("post_rst_idx", 128'(bus0.frame_idx), 128'd0);
        check("post_rst_data", bus0.tx_dataout, FB);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
